seq_divider: RTL
================

Name: seq_divider

Overview:
- Sequential unsigned restoring divider: the inverse operation of the team's 16x16 CLA multiplier.
- Takes a 2*WIDTH-bit dividend (e.g. a multiplier product) and a WIDTH-bit divisor, and returns a WIDTH-bit quotient and a WIDTH-bit remainder.
- Produces one quotient bit per clock; start/done handshake.
- Sits beside the multiplier in the arithmetic datapath and is used to recover a factor or check a product.

Parameters:
- WIDTH, 16, divisor/quotient/remainder width. The dividend is 2*WIDTH bits.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- dividend  input  2*WIDTH  unsigned dividend; sampled on the accepting edge
- divisor  input  WIDTH  unsigned divisor; sampled on the accepting edge
- busy  output  1  high while an operation is in progress (BUSY state)
- done  output  1  one-cycle pulse; results are valid in that cycle
- quotient  output  WIDTH  result quotient; held until the next accepted start
- remainder  output  WIDTH  result remainder; held until the next accepted start
- error  output  1  set with done on divide-by-zero or quotient overflow; held with the results

Behaviour:
- Reset (asynchronous, active-high):
  - State goes to IDLE.
  - busy=0, done=0, error=0, quotient=0, remainder=0.
  - Internal registers are cleared.
  - Reset mid-operation aborts the operation; no done pulse is produced.
- States: IDLE, BUSY, DONE.
- IDLE, start=1 at edge N:
  - Latch the operands.
  - Error check, evaluated on the inputs at edge N:
    - divisor==0 -> div-by-zero.
    - dividend[2W-1:W] >= divisor -> overflow.
  - Error case: go to DONE.
    - In the DONE cycle: error=1, quotient=all-ones, remainder=dividend[W-1:0].
    - done is high during the cycle after edge N.
  - Normal case: go to BUSY.
    - busy=1 after edge N.
    - Partial remainder R (W+1 bits) = {0, dividend[2W-1:W]}.
    - Shift register holds dividend[W-1:0].
    - Iteration counter = 0.
- BUSY, one iteration per edge (edges N+1 .. N+W):
  - R' = {R[W-1:0], next dividend bit, MSB first}.
  - If R' >= {0, divisor}: R = R' - divisor and shift in q bit 1.
  - Else: R = R' and shift in q bit 0.
  - The counter increments each iteration.
  - On the W-th iteration (edge N+W), go to DONE and load quotient/remainder from the final values.
- DONE, one cycle:
  - done=1, busy=0.
  - Normal completion: error=0.
  - Go to IDLE on the next edge.
  - A start during DONE is ignored.
- Latency, start edge to done cycle:
  - Normal: done is high in the cycle following edge N+W (W+1 cycles after acceptance; 17 for W=16).
  - Error: done is high in the cycle following edge N (1 cycle).
- start while BUSY or DONE: ignored. Inputs may change freely while busy; the latched operands are used.
- Back-to-back: a start in the IDLE cycle immediately after DONE is accepted.
- Arithmetic/width rules:
  - Compare and subtract use W+1 bits, so no carry is lost (R' < 2*divisor).
  - The final remainder fits in W bits.
  - Invariant for valid results: quotient*divisor + remainder == dividend, and remainder < divisor.
- Output hold rules:
  - quotient, remainder and error hold their values from done until the next accepted start.
  - On acceptance they are not cleared; they update only at DONE.

Test Plan:
- Recover a multiplier factor: dividend=32'h003F7F81 (0x7FFF*0x7F), divisor=16'h007F, start -> 17 cycles later done=1, quotient=16'h7FFF, remainder=0, error=0.
- Small values with remainder: dividend=100, divisor=7 -> quotient=14, remainder=2, error=0. Check busy is high for exactly 16 cycles and done is high for exactly 1 cycle.
- Boundary values: dividend=32'hFFFE0001, divisor=16'hFFFF -> quotient=16'hFFFF, remainder=0. Also dividend=32'h0000FFFF, divisor=1 -> quotient=16'hFFFF, remainder=0.
- Error cases:
  - divisor=0 -> done in the cycle after the start edge, error=1, quotient=16'hFFFF, remainder=dividend[15:0].
  - dividend=32'h00100000, divisor=16'h0010 (overflow) -> same error response.
- Handshake and reset:
  - Pulse start again with different operands at cycle 5 of BUSY -> ignored; results match the first operands.
  - Assert reset at cycle 8 of BUSY -> busy=0 and all outputs 0 immediately, with no done pulse. A subsequent start works normally.
- Randomized: 200 random operands with dividend[31:16] < divisor. Check quotient*divisor + remainder == dividend and remainder < divisor, with back-to-back starts.

Source files
------------

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
//  Module   : seq_divider
//  Purpose  : Sequential unsigned restoring divider. Divides a 2*WIDTH-bit
//             dividend by a WIDTH-bit divisor and produces one quotient bit
//             per clock. Uses a start/done handshake.
//  Ports    :
//    clk        - rising-edge clock
//    reset      - asynchronous, active-high reset
//    start      - operation request, sampled only while idle
//    dividend   - 2*WIDTH-bit unsigned dividend, latched on acceptance
//    divisor    - WIDTH-bit unsigned divisor, latched on acceptance
//    busy       - high while iterations are in progress
//    done       - one-cycle pulse, results valid in that cycle
//    quotient   - WIDTH-bit quotient, held until the next completion
//    remainder  - WIDTH-bit remainder, held until the next completion
//    error      - divide-by-zero or quotient overflow, held with results
//  Revision : 1.0 - initial release
// ============================================================================
module seq_divider #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [2*WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]     divisor,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     quotient,
    output logic [WIDTH-1:0]     remainder,
    output logic                 error
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_accept;
    logic               w_busy;
    logic               w_done;

    logic [WIDTH-1:0]   r_rem;        // partial remainder, always < divisor
    logic [WIDTH-1:0]   r_shift;      // dividend low bits out, quotient bits in
    logic [WIDTH-1:0]   r_divisor;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_quot;
    logic [WIDTH-1:0]   r_remout;
    logic               r_error;

    logic               w_err_in;
    logic               w_last;
    logic [WIDTH:0]     w_rprime;
    logic               w_ge;
    logic [WIDTH-1:0]   w_diff;
    logic [WIDTH-1:0]   w_rnext;
    logic [WIDTH-1:0]   w_qnext;

    // A high half >= divisor means the quotient cannot fit in WIDTH bits.
    // This also covers divisor==0, since any value is >= 0.
    assign w_err_in = (dividend[2*WIDTH-1:WIDTH] >= divisor);

    // One restoring step. R' is WIDTH+1 bits so the shifted-out MSB of the
    // partial remainder takes part in the compare; since R' < 2*divisor the
    // difference always fits back into WIDTH bits.
    assign w_rprime = {r_rem, r_shift[WIDTH-1]};
    assign w_ge     = (w_rprime >= {1'b0, r_divisor});
    assign w_diff   = WIDTH'(w_rprime - {1'b0, r_divisor});
    assign w_rnext  = w_ge ? w_diff : w_rprime[WIDTH-1:0];
    assign w_qnext  = {r_shift[WIDTH-2:0], w_ge};
    assign w_last   = (r_cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = w_err_in ? S_DONE : S_BUSY;
                end
            end
            S_BUSY: begin
                w_busy = 1'b1;
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rem     <= '0;
            r_shift   <= '0;
            r_divisor <= '0;
            r_cnt     <= '0;
            r_quot    <= '0;
            r_remout  <= '0;
            r_error   <= 1'b0;
        end else if (w_accept) begin
            r_divisor <= divisor;
            if (w_err_in) begin
                // Error results go straight to the outputs for the DONE cycle.
                r_quot   <= '1;
                r_remout <= dividend[WIDTH-1:0];
                r_error  <= 1'b1;
            end else begin
                r_rem   <= dividend[2*WIDTH-1:WIDTH];
                r_shift <= dividend[WIDTH-1:0];
                r_cnt   <= '0;
            end
        end else if (r_state == S_BUSY) begin
            r_rem   <= w_rnext;
            r_shift <= w_qnext;
            r_cnt   <= r_cnt + CW'(1);
            if (w_last) begin
                r_quot   <= w_qnext;
                r_remout <= w_rnext;
                r_error  <= 1'b0;
            end
        end
    end

    assign busy      = w_busy;
    assign done      = w_done;
    assign quotient  = r_quot;
    assign remainder = r_remout;
    assign error     = r_error;

endmodule
`default_nettype wire
